// File: rtl/dft_float_addsub_pipe.sv
// Pipelined floating-point add/subtract. Subnormals flush to zero, results round to nearest-even.
// Stage 1 unpacks and orders the operands; align/add/normalise/round feed the output register.
module dft_float_addsub_pipe #(
  parameter int EW     = 8,
  parameter int MW     = 23,
  parameter int STAGES = 2
) (
  input  logic           aclk,
  input  logic           arst,
  input  logic           astall,
  input  logic           in_valid,
  input  logic           sub,
  input  logic           a_sign,
  input  logic [EW-1:0]  a_exp,
  input  logic [MW-1:0]  a_man,
  input  logic           b_sign,
  input  logic [EW-1:0]  b_exp,
  input  logic [MW-1:0]  b_man,
  output logic [EW+MW:0] x,
  output logic           out_valid
);
  localparam int XW = 1 + EW + MW;
  localparam int FW = MW + 4;  // hidden bit, stored mantissa, guard, round, sticky
  localparam int EXP_MAX = (1 << EW) - 1;
  localparam logic [EW-1:0] EXP_ONES = {EW{1'b1}};
  localparam logic [XW-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MW-1){1'b0}}};

  typedef struct packed {
    logic          valid;
    logic          spec;
    logic [XW-1:0] spec_x;
    logic          sign;
    logic          eff_sub;
    logic [EW-1:0] exp_l;
    logic [EW-1:0] diff;
    logic [MW:0]   man_l;
    logic [MW:0]   man_s;
  } s1_t;

  logic             w_b_sign, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_big;
  logic [EW+MW-1:0] w_a_key, w_b_key;
  logic [MW:0]      w_a_mant, w_b_mant;
  s1_t              w_s1, w_back;

  always_comb begin
    w_b_sign = b_sign ^ sub;
    w_a_zero = (a_exp == '0);
    w_b_zero = (b_exp == '0);
    w_a_inf  = (a_exp == EXP_ONES) && (a_man == '0);
    w_b_inf  = (b_exp == EXP_ONES) && (b_man == '0);
    w_a_nan  = (a_exp == EXP_ONES) && (a_man != '0);
    w_b_nan  = (b_exp == EXP_ONES) && (b_man != '0);
    w_a_key  = w_a_zero ? '0 : {a_exp, a_man};
    w_b_key  = w_b_zero ? '0 : {b_exp, b_man};
    w_a_mant = w_a_zero ? '0 : {1'b1, a_man};
    w_b_mant = w_b_zero ? '0 : {1'b1, b_man};
    w_a_big  = (w_a_key >= w_b_key);
    w_s1 = '0;
    // Bubbles carry all-zero data so nothing downstream can go X.
    if (in_valid) begin
      w_s1.valid   = 1'b1;
      w_s1.eff_sub = a_sign ^ w_b_sign;
      if (w_a_big) begin
        w_s1.sign  = a_sign;
        w_s1.exp_l = a_exp;
        w_s1.diff  = a_exp - b_exp;
        w_s1.man_l = w_a_mant;
        w_s1.man_s = w_b_mant;
      end else begin
        w_s1.sign  = w_b_sign;
        w_s1.exp_l = b_exp;
        w_s1.diff  = b_exp - a_exp;
        w_s1.man_l = w_b_mant;
        w_s1.man_s = w_a_mant;
      end
      if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a_sign != w_b_sign))) begin
        w_s1.spec   = 1'b1;
        w_s1.spec_x = QNAN;
      end else if (w_a_inf) begin
        w_s1.spec   = 1'b1;
        w_s1.spec_x = {a_sign, EXP_ONES, {MW{1'b0}}};
      end else if (w_b_inf) begin
        w_s1.spec   = 1'b1;
        w_s1.spec_x = {w_b_sign, EXP_ONES, {MW{1'b0}}};
      end else if (w_a_zero && w_b_zero) begin
        w_s1.spec   = 1'b1;
        w_s1.spec_x = {a_sign & w_b_sign, {(EW+MW){1'b0}}};
      end
    end
  end

  generate
    if (STAGES == 1) begin : g_comb_front
      assign w_back = w_s1;
    end else begin : g_reg_front
      s1_t r_front [STAGES-1];
      always_ff @(posedge aclk) begin
        if (arst) begin
          for (int i = 0; i < STAGES-1; i++) r_front[i] <= '0;
        end else if (!astall) begin
          r_front[0] <= w_s1;
          for (int i = 1; i < STAGES-1; i++) r_front[i] <= r_front[i-1];
        end
      end
      assign w_back = r_front[STAGES-2];
    end
  endgenerate

  function automatic int lzc(input logic [FW-1:0] v);
    int n;
    n = FW;
    for (int i = 0; i < FW; i++) if (v[i]) n = FW - 1 - i;
    return n;
  endfunction

  logic [FW-1:0] w_ext_s, w_align, w_norm;
  logic          w_sticky, w_rnd_up;
  logic [FW:0]   w_sum;
  int            w_lz, w_exp_n, w_exp_r;
  logic [MW+1:0] w_mant_r;
  logic [MW-1:0] w_man_out;
  logic [XW-1:0] w_res;

  always_comb begin
    w_ext_s  = {w_back.man_s, 3'b000};
    w_sticky = |(w_ext_s & ~({FW{1'b1}} << w_back.diff));
    w_align  = (w_ext_s >> w_back.diff) | {{(FW-1){1'b0}}, w_sticky};
    if (w_back.eff_sub) w_sum = {1'b0, w_back.man_l, 3'b000} - {1'b0, w_align};
    else                w_sum = {1'b0, w_back.man_l, 3'b000} + {1'b0, w_align};
    w_lz = 0;
    if (w_sum[FW]) begin
      w_norm  = w_sum[FW:1] | {{(FW-1){1'b0}}, w_sum[0]};
      w_exp_n = int'(w_back.exp_l) + 1;
    end else begin
      w_lz    = lzc(w_sum[FW-1:0]);
      w_norm  = w_sum[FW-1:0] << w_lz;
      w_exp_n = int'(w_back.exp_l) - w_lz;
    end
    // Ties go to the even neighbour: round up only when the kept LSB is odd.
    w_rnd_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mant_r = {1'b0, w_norm[FW-1:3]} + {{(MW+1){1'b0}}, w_rnd_up};
    if (w_mant_r[MW+1]) begin
      w_man_out = w_mant_r[MW:1];
      w_exp_r   = w_exp_n + 1;
    end else begin
      w_man_out = w_mant_r[MW-1:0];
      w_exp_r   = w_exp_n;
    end
    if (w_back.spec)             w_res = w_back.spec_x;
    else if (w_sum == '0)        w_res = '0;
    else if (w_exp_r >= EXP_MAX) w_res = {w_back.sign, EXP_ONES, {MW{1'b0}}};
    else if (w_exp_r <= 0)       w_res = {w_back.sign, {(EW+MW){1'b0}}};
    else                         w_res = {w_back.sign, w_exp_r[EW-1:0], w_man_out};
  end

  logic [XW-1:0] r_x;
  logic          r_out_valid;

  always_ff @(posedge aclk) begin
    if (arst) begin
      r_x         <= '0;
      r_out_valid <= 1'b0;
    end else if (!astall) begin
      r_x         <= w_res;
      r_out_valid <= w_back.valid;
    end
  end

  assign x         = r_x;
  assign out_valid = r_out_valid;
endmodule

// File: tb/tb_dft_float_addsub_pipe.sv
// Bench for dft_float_addsub_pipe: default E8/M23 2-stage instance plus an E5/M10 4-stage instance.
module tb_dft_float_addsub_pipe;
  localparam int S0 = 2;
  localparam int S1 = 4;
  localparam int NV = 20;

  logic        clk = 1'b0;
  logic        arst, astall, in_valid0, in_valid1, sub0, sub1;
  logic [31:0] a0, b0, x0, prev_x0;
  logic [15:0] a1, b1, x1, prev_x1;
  logic        v0, v1, prev_v0, prev_v1;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;
  logic [31:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int          lat_q0[$];
  int          lat_q1[$];

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] e;
  } vec_t;

  vec_t vecs [NV] = '{
    '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000},
    '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000},
    '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000},
    '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001},
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000},
    '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000},
    '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000},
    '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000},
    '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000},
    '{32'h00000001, 32'h00000000, 1'b0, 32'h00000000},
    '{32'h3F800000, 32'h33000000, 1'b1, 32'h3F800000},
    '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF},
    '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000},
    '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000},
    '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000},
    '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000},
    '{32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000},
    '{32'h3F800000, 32'h00400000, 1'b0, 32'h3F800000},
    '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000},
    '{32'h3F800000, 32'hC0400000, 1'b0, 32'hC0000000}
  };

  dft_float_addsub_pipe #(.EW(8), .MW(23), .STAGES(S0)) u_dut0 (
    .aclk(clk), .arst(arst), .astall(astall), .in_valid(in_valid0), .sub(sub0),
    .a_sign(a0[31]), .a_exp(a0[30:23]), .a_man(a0[22:0]),
    .b_sign(b0[31]), .b_exp(b0[30:23]), .b_man(b0[22:0]),
    .x(x0), .out_valid(v0)
  );

  dft_float_addsub_pipe #(.EW(5), .MW(10), .STAGES(S1)) u_dut1 (
    .aclk(clk), .arst(arst), .astall(astall), .in_valid(in_valid1), .sub(sub1),
    .a_sign(a1[15]), .a_exp(a1[14:10]), .a_man(a1[9:0]),
    .b_sign(b1[15]), .b_exp(b1[14:10]), .b_man(b1[9:0]),
    .x(x1), .out_valid(v1)
  );

  // Clock / timeout
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  // Scoreboard: inputs are still stable at the negedge, so they tell what the last posedge did.
  initial forever begin
    @(negedge clk);
    if (arst) begin
      exp_q0.delete(); lat_q0.delete();
      exp_q1.delete(); lat_q1.delete();
    end else if (!astall) begin
      en_cnt++;
      if (v0) begin
        check_eq("q0_nonempty", 64'(exp_q0.size() > 0), 64'd1);
        if (exp_q0.size() > 0) begin
          check_eq("x0", x0, exp_q0.pop_front());
          check_eq("lat0", en_cnt, lat_q0.pop_front());
        end
      end
      if (v1) begin
        check_eq("q1_nonempty", 64'(exp_q1.size() > 0), 64'd1);
        if (exp_q1.size() > 0) begin
          check_eq("x1", x1, exp_q1.pop_front());
          check_eq("lat1", en_cnt, lat_q1.pop_front());
        end
      end
    end else begin
      check_eq("hold_x0", x0, prev_x0);
      check_eq("hold_v0", v0, prev_v0);
      check_eq("hold_x1", x1, prev_x1);
      check_eq("hold_v1", v1, prev_v1);
    end
    prev_x0 = x0; prev_v0 = v0;
    prev_x1 = x1; prev_v1 = v1;
  end

  // Driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int dut, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [31:0] expv, input bit rnd);
    int tries = 0;
    if (dut == 0) begin
      a0 = a; b0 = b; sub0 = s; in_valid0 = 1'b1; in_valid1 = 1'b0;
      exp_q0.push_back(expv);
      lat_q0.push_back(en_cnt + S0);
    end else begin
      a1 = a[15:0]; b1 = b[15:0]; sub1 = s; in_valid1 = 1'b1; in_valid0 = 1'b0;
      exp_q1.push_back(expv[15:0]);
      lat_q1.push_back(en_cnt + S1);
    end
    do begin
      astall = rnd && (tries < 4) && ($urandom_range(0, 3) == 0);
      tries++;
      step();
    end while (astall);
  endtask

  task automatic idle(input int n);
    in_valid0 = 1'b0; in_valid1 = 1'b0; astall = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain();
    int budget = 0;
    in_valid0 = 1'b0; in_valid1 = 1'b0; astall = 1'b0;
    while ((exp_q0.size() > 0 || exp_q1.size() > 0) && budget < 60) begin
      step();
      budget++;
    end
    check_eq("drain0", exp_q0.size(), 0);
    check_eq("drain1", exp_q1.size(), 0);
  endtask

  initial begin
    arst = 1'b1; astall = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0;
    sub0 = 1'b0; sub1 = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) step();
    check_eq("rst_x0", x0, 0);
    check_eq("rst_v0", v0, 0);
    check_eq("rst_x1", x1, 0);
    check_eq("rst_v1", v1, 0);
    arst = 1'b0;
    idle(2);

    for (int i = 0; i < NV; i++) send(0, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e, 1'b0);
    drain();

    // Deterministic stall: three frozen edges between two accepted operations.
    send(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0);
    send(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0);
    astall = 1'b1; in_valid0 = 1'b1; a0 = 32'h12345678; b0 = 32'h12345678;
    repeat (3) step();
    check_eq("stall_frozen_x", x0, 32'h40400000);
    check_eq("stall_frozen_v", v0, 1);
    send(0, 32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 1'b0);
    check_eq("stall_lat_x", x0, 32'h40000000);
    check_eq("stall_lat_v", v0, 1);
    send(0, 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0);
    drain();

    // Reset while stalled with results in flight.
    send(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0);
    send(0, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0);
    send(1, 32'h00003C00, 32'h00003C00, 1'b0, 32'h00004000, 1'b0);
    astall = 1'b1; arst = 1'b1; in_valid0 = 1'b0; in_valid1 = 1'b0;
    step();
    check_eq("midrst_x0", x0, 0);
    check_eq("midrst_v0", v0, 0);
    check_eq("midrst_x1", x1, 0);
    check_eq("midrst_v1", v1, 0);
    arst = 1'b0;
    idle(8);
    check_eq("no_stale_v0", v0, 0);
    check_eq("no_stale_v1", v1, 0);

    // Random stream with random stalls and gaps.
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, NV - 1);
      send(0, vecs[k].a, vecs[k].b, vecs[k].s, vecs[k].e, 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    drain();

    // Half-precision, four-stage instance.
    send(1, 32'h00003C00, 32'h00003C00, 1'b0, 32'h00004000, 1'b0);
    send(1, 32'h00007BFF, 32'h00007BFF, 1'b0, 32'h00007C00, 1'b0);
    send(1, 32'h00003C00, 32'h00004000, 1'b1, 32'h0000BC00, 1'b0);
    send(1, 32'h00007C00, 32'h0000FC00, 1'b0, 32'h00007E00, 1'b0);
    for (int i = 0; i < 12; i++) begin
      send(1, 32'h00003C00, 32'h00004000, i[0], i[0] ? 32'h0000BC00 : 32'h00004200, 1'b1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
